seq_parser_stream: RTL
======================

// Module: seq_parser_stream
// PURPOSE
//  Parametrised packet assembler for word streams; next generation of the sequence parser.
//  Checks each packet's leading sync word, then packs the payload words MSB-first into one
//  wide output record. Records queue in a DEPTH-entry output FIFO.
//  Overflow and sync errors are reported; a full FIFO either drops the packet or back-pressures.
//  Sits between the serial ingress link and the wide-record consumer.
// PARAMETERS
//  IN_W       32            input word width
//  OUT_W      296           output record width
//  DEPTH      2             output FIFO entries (>=1)
//  SYNC       32'hA5A55A5A  required first word of every packet (IN_W bits)
//  STALL_MODE 0             0: drop packet when FIFO full; 1: stall input instead
//  localparam MAX_WORDS = ceil(OUT_W/IN_W) (10 at defaults); LEN_W = $clog2(MAX_WORDS+1)
// PORTS
//  clk           in   1      single clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  dataIn        in   IN_W   input word
//  dataIn_val    in   1      input word valid
//  dataIn_ready  out  1      input can be accepted; beat = val&ready
//  dataIn_last   in   1      marks final word of packet
//  dataOut       out  OUT_W  assembled record (FIFO head)
//  dataOut_len   out  LEN_W  payload word count of head record
//  dataOut_val   out  1      FIFO non-empty
//  dataOut_ready in   1      consumer takes head when val&ready
//  packetLost    out  1      one-cycle pulse per dropped/erroneous packet
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, assembly reg and count = 0; dataOut_val=0,
//   packetLost=0, dataOut=0, dataOut_len=0. dataIn_ready=0 while reset high.
//  Reset mid-packet: partial packet discarded silently, no packetLost.
//  FSM (advances only on accepted beats, except HOLD):
//   IDLE:    word==SYNC & !last -> COLLECT; word==SYNC & last (empty packet) -> error;
//            word!=SYNC & !last -> DISCARD; word!=SYNC & last -> error.
//   COLLECT: word k (0-based) stored at bits [OUT_W-1-k*IN_W -: IN_W]; final partial slot
//            keeps upper bits of the word (default: word 9 -> bits [7:0] = word[31:24]).
//            Word arriving with count==MAX_WORDS -> overflow -> DISCARD (or error if last).
//            last -> complete: push {record, count}; -> IDLE (or HOLD, see below).
//   DISCARD: swallow words until last; on last -> error, -> IDLE.
//   HOLD:    STALL_MODE=1 only; dataIn_ready=0; pushes held record when FIFO has space,
//            then -> IDLE.
//  Error: packetLost=1 for exactly the cycle after the last beat; nothing pushed.
//  Unused record bits (beyond count) are zero.
//  Latency: push on the edge that accepts the last beat; dataOut_val=1 the next cycle.
//  FIFO: show-ahead; pop on dataOut_val&dataOut_ready. A pop and a push in one cycle
//   when full: the push is accepted (no loss, no stall).
//  FIFO full at completion, no pop that cycle: STALL_MODE=0 -> packet dropped,
//   packetLost pulse. STALL_MODE=1 -> HOLD, no loss.
//  dataIn_ready = !reset & (state!=HOLD); combinational from state only.
//  Only one packetLost pulse per packet, even if it had several errors.
// CONFIGURATION
//  PARSER_STATS_EN defined: adds outputs stat_pkt_ok[15:0] and stat_pkt_lost[15:0].
//   These count FIFO pushes and packetLost pulses; they saturate at 16'hFFFF and clear on reset.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 SYNC,0x11111111,0x22222222,0x33333333(last), ready=1 -> next cycle val=1, len=3,
//    dataOut[295:200]=112233 pattern, [199:0]=0, packetLost=0
//  2 0xDEADBEEF,0x1,0x2(last) -> packetLost pulse 1 cycle after last; dataOut_val stays 0
//  3 SYNC+10 words (word9=0xABCDEF01) -> len=10, dataOut[7:0]=0xAB;
//    SYNC+11 words -> packetLost, no push
//  4 STALL_MODE=0, dataOut_ready=0, three good packets -> first two queued, third gives
//    packetLost; then ready=1 -> two records popped in order
//  5 STALL_MODE=1, same stimulus -> dataIn_ready=0 after third last until first pop;
//    three records delivered, packetLost never 1
//  6 reset high 1 cycle after SYNC+2 words -> all outputs 0 next cycle;
//    following clean packet delivered correctly

Source files
------------

// File: rtl/seq_parser_stream_if.sv
// Word-stream ingress and wide-record egress bundle for seq_parser_stream.
// The parser binds to the slave modport; the producer/consumer side uses master.
interface seq_parser_stream_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 296,
  parameter int LEN_W = 4
);
  logic [IN_W-1:0]  dataIn;
  logic             dataIn_val;
  logic             dataIn_ready;
  logic             dataIn_last;
  logic [OUT_W-1:0] dataOut;
  logic [LEN_W-1:0] dataOut_len;
  logic             dataOut_val;
  logic             dataOut_ready;
  logic             packetLost;

  modport slave (
    input  dataIn, dataIn_val, dataIn_last, dataOut_ready,
    output dataIn_ready, dataOut, dataOut_len, dataOut_val, packetLost
  );

  modport master (
    output dataIn, dataIn_val, dataIn_last, dataOut_ready,
    input  dataIn_ready, dataOut, dataOut_len, dataOut_val, packetLost
  );
endinterface

// File: rtl/seq_parser_stream.sv
// Sync-checked packet assembler: packs payload words MSB-first into wide records queued in a FIFO.
// Optional PARSER_STATS_EN adds saturating stat_pkt_ok / stat_pkt_lost counters.
module seq_parser_stream #(
  parameter int              IN_W       = 32,
  parameter int              OUT_W      = 296,
  parameter int              DEPTH      = 2,
  parameter logic [IN_W-1:0] SYNC       = 32'hA5A55A5A,
  parameter int              STALL_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PARSER_STATS_EN
  output logic [15:0]        stat_pkt_ok,
  output logic [15:0]        stat_pkt_lost,
`endif
  seq_parser_stream_if.slave bus
);
  localparam int MAX_WORDS = (OUT_W + IN_W - 1) / IN_W;
  localparam int LEN_W     = $clog2(MAX_WORDS + 1);
  localparam int EXT_W     = MAX_WORDS * IN_W;
  localparam int ENT_W     = OUT_W + LEN_W;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             stateNext_s;
  logic [EXT_W-1:0]   asmExt_r;
  logic [EXT_W-1:0]   asmNext_s;
  logic [EXT_W-1:0]   wordExt_s;
  logic [LEN_W-1:0]   count_r;
  logic [LEN_W-1:0]   countNext_s;
  logic               packetLost_r;
  logic               lostNext_s;
  logic               push_s;
  logic               pop_s;
  logic               space_s;
  logic               beat_s;
  logic               isSync_s;
  logic               inReady_s;
  logic [ENT_W-1:0]   pushEntry_s;
  logic [ENT_W-1:0]   headEntry_s;
  logic [ENT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wrPtr_r;
  logic [PTR_W-1:0]   rdPtr_r;
  logic [CNT_W-1:0]   fifoCnt_r;
  logic               outVal_s;

  assign inReady_s = ~reset & (state_r != HOLD);
  assign beat_s    = bus.dataIn_val & inReady_s;
  assign isSync_s  = (bus.dataIn == SYNC);
  assign outVal_s  = (fifoCnt_r != {CNT_W{1'b0}});
  assign pop_s     = outVal_s & bus.dataOut_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign space_s   = (fifoCnt_r != FULL_CNT) | pop_s;

  // The record is built in a slot-aligned buffer; the final partial slot keeps the word's upper bits.
  assign wordExt_s   = (EXT_W'(bus.dataIn) << (EXT_W - IN_W)) >> (int'(count_r) * IN_W);
  assign pushEntry_s = {asmNext_s[EXT_W-1 -: OUT_W], countNext_s};

  // Next-state, assembly and push/loss decisions.
  always_comb begin
    stateNext_s = state_r;
    asmNext_s   = asmExt_r;
    countNext_s = count_r;
    push_s      = 1'b0;
    lostNext_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          if (isSync_s) begin
            asmNext_s   = {EXT_W{1'b0}};
            countNext_s = {LEN_W{1'b0}};
            if (bus.dataIn_last) begin
              lostNext_s = 1'b1;
            end else begin
              stateNext_s = COLLECT;
            end
          end else begin
            if (bus.dataIn_last) begin
              lostNext_s = 1'b1;
            end else begin
              stateNext_s = DISCARD;
            end
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      COLLECT: begin
        if (beat_s) begin
          if (count_r == MAX_CNT) begin
            if (bus.dataIn_last) begin
              lostNext_s  = 1'b1;
              stateNext_s = IDLE;
            end else begin
              stateNext_s = DISCARD;
            end
          end else begin
            asmNext_s   = asmExt_r | wordExt_s;
            countNext_s = count_r + LEN_W'(1'b1);
            if (bus.dataIn_last) begin
              if (space_s) begin
                push_s      = 1'b1;
                stateNext_s = IDLE;
              end else if (STALL_MODE != 0) begin
                stateNext_s = HOLD;
              end else begin
                lostNext_s  = 1'b1;
                stateNext_s = IDLE;
              end
            end else begin
              stateNext_s = COLLECT;
            end
          end
        end else begin
          stateNext_s = COLLECT;
        end
      end
      DISCARD: begin
        if (beat_s && bus.dataIn_last) begin
          lostNext_s  = 1'b1;
          stateNext_s = IDLE;
        end else begin
          stateNext_s = DISCARD;
        end
      end
      HOLD: begin
        if (space_s) begin
          push_s      = 1'b1;
          stateNext_s = IDLE;
        end else begin
          stateNext_s = HOLD;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Parser state, assembly buffer and loss pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      asmExt_r     <= {EXT_W{1'b0}};
      count_r      <= {LEN_W{1'b0}};
      packetLost_r <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      asmExt_r     <= asmNext_s;
      count_r      <= countNext_s;
      packetLost_r <= lostNext_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_r   <= {PTR_W{1'b0}};
      rdPtr_r   <= {PTR_W{1'b0}};
      fifoCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wrPtr_r <= (wrPtr_r == LAST_PTR) ? {PTR_W{1'b0}} : wrPtr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rdPtr_r <= (rdPtr_r == LAST_PTR) ? {PTR_W{1'b0}} : rdPtr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   fifoCnt_r <= fifoCnt_r + CNT_W'(1'b1);
        2'b01:   fifoCnt_r <= fifoCnt_r - CNT_W'(1'b1);
        default: fifoCnt_r <= fifoCnt_r;
      endcase
    end
  end

  // FIFO storage; stale entries are masked at the output by the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wrPtr_r] <= pushEntry_s;
    end
  end

  assign headEntry_s      = mem_r[rdPtr_r];
  assign bus.dataIn_ready = inReady_s;
  assign bus.dataOut_val  = outVal_s;
  assign bus.dataOut      = outVal_s ? headEntry_s[ENT_W-1 -: OUT_W] : {OUT_W{1'b0}};
  assign bus.dataOut_len  = outVal_s ? headEntry_s[LEN_W-1:0] : {LEN_W{1'b0}};
  assign bus.packetLost   = packetLost_r;

`ifdef PARSER_STATS_EN
  logic [15:0] statOk_r;
  logic [15:0] statLost_r;

  // Saturating delivered / lost packet counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      statOk_r   <= 16'h0000;
      statLost_r <= 16'h0000;
    end else begin
      if (push_s && (statOk_r != 16'hFFFF)) begin
        statOk_r <= statOk_r + 16'h0001;
      end
      if (packetLost_r && (statLost_r != 16'hFFFF)) begin
        statLost_r <= statLost_r + 16'h0001;
      end
    end
  end

  assign stat_pkt_ok   = statOk_r;
  assign stat_pkt_lost = statLost_r;
`endif
endmodule
